// File: rtl/line_write_scheduler_pkg.sv
// rtl/line_write_scheduler_pkg.sv - shared buffer-control constants and scheduler state encoding
package line_write_scheduler_pkg;

    localparam int X_MAC            = 4;
    localparam int DEF_ADDR_LEN     = 13;
    localparam int DEF_MAX_LINE_LEN = 10;
    localparam int DEF_LINE_CNT_LEN = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_GUARD = 3'd3,
        ST_DONE  = 3'd4
    } lws_state_t;

endpackage

// File: rtl/line_write_scheduler_lane_addr_step.sv
// rtl/line_write_scheduler_lane_addr_step.sv - one lane's start address advanced by the line stride
module lane_addr_step
    import line_write_scheduler_pkg::*;
#(
    parameter int ADDR_LEN = DEF_ADDR_LEN
) (
    input  logic [ADDR_LEN-1:0] addr,
    input  logic [ADDR_LEN-1:0] stride,
    output logic [ADDR_LEN-1:0] next_addr
);

    // Natural overflow gives the modulo-2^ADDR_LEN wrap of the buffer address space.
    assign next_addr = addr + stride;

endmodule

// File: rtl/line_write_scheduler.sv
// rtl/line_write_scheduler.sv - per-line write-controller sequencing over a tile; STAT_EN adds stall_cycles
module line_write_scheduler
    import line_write_scheduler_pkg::*;
#(
    parameter int ADDR_LEN     = DEF_ADDR_LEN,
    parameter int MAX_LINE_LEN = DEF_MAX_LINE_LEN,
    parameter int LINE_CNT_LEN = DEF_LINE_CNT_LEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_LEN*X_MAC-1:0] base_addr,
    input  logic [ADDR_LEN-1:0]       addr_stride,
    input  logic [LINE_CNT_LEN-1:0]   num_lines,
    input  logic [MAX_LINE_LEN-1:0]   linelen,
    input  logic                      pooled,
    input  logic [1:0]                valid_mac,
    output logic                      busy,
    output logic                      done,
    output logic                      wc_conf,
    output logic [ADDR_LEN*X_MAC-1:0] wc_st_addr,
    output logic [MAX_LINE_LEN-1:0]   wc_linelen,
    output logic                      wc_pooled,
    output logic [1:0]                wc_valid_mac,
    input  logic                      wc_idle
`ifdef STAT_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    lws_state_t                state_q;
    lws_state_t                state_d;
    logic [LINE_CNT_LEN-1:0]   lines_left;
    logic [ADDR_LEN-1:0]       stride_q;
    logic [ADDR_LEN*X_MAC-1:0] cur_addr;
    logic [ADDR_LEN*X_MAC-1:0] step_addr;
    logic                      accept;

    assign accept = (state_q == ST_IDLE) && start;

    for (genvar j = 0; j < X_MAC; j++) begin : g_lane
        lane_addr_step #(
            .ADDR_LEN (ADDR_LEN)
        ) u_step (
            .addr      (cur_addr[j*ADDR_LEN +: ADDR_LEN]),
            .stride    (stride_q),
            .next_addr (step_addr[j*ADDR_LEN +: ADDR_LEN])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_WAIT;
            ST_WAIT: begin
                if (lines_left == '0) state_d = ST_DONE;
                else if (wc_idle)     state_d = ST_ISSUE;
            end
            // GUARD skips the cycle where the controller has not yet dropped idle after conf.
            ST_ISSUE: state_d = ST_GUARD;
            ST_GUARD: state_d = ST_WAIT;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lines_left   <= '0;
            stride_q     <= '0;
            cur_addr     <= '0;
            wc_linelen   <= '0;
            wc_pooled    <= 1'b0;
            wc_valid_mac <= 2'b00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lines_left   <= (linelen == '0) ? '0 : num_lines;
                stride_q     <= addr_stride;
                cur_addr     <= base_addr;
                wc_linelen   <= linelen;
                wc_pooled    <= pooled;
                wc_valid_mac <= valid_mac;
            end else if (state_q == ST_ISSUE) begin
                lines_left <= lines_left - 1'b1;
                cur_addr   <= step_addr;
            end
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign wc_conf    = (state_q == ST_ISSUE);
    assign wc_st_addr = cur_addr;

`ifdef STAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
        end else if ((state_q == ST_WAIT) && (lines_left != '0) && !wc_idle
                     && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_line_write_scheduler.sv
// tb/tb_line_write_scheduler.sv - scoreboard bench for line_write_scheduler
module tb_line_write_scheduler;

    localparam int AL = 13;
    localparam int XM = 4;
    localparam int W  = AL * XM;

    typedef struct {
        int           cyc;
        logic [W-1:0] addr;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  base_addr;
    logic [AL-1:0] addr_stride;
    logic [9:0]    num_lines;
    logic [9:0]    linelen;
    logic          pooled;
    logic [1:0]    valid_mac;
    logic          busy;
    logic          done;
    logic          wc_conf;
    logic [W-1:0]  wc_st_addr;
    logic [9:0]    wc_linelen;
    logic          wc_pooled;
    logic [1:0]    wc_valid_mac;
    logic          wc_idle;
`ifdef STAT_EN
    logic [31:0]   stall_cycles;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    line_write_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .addr_stride  (addr_stride),
        .num_lines    (num_lines),
        .linelen      (linelen),
        .pooled       (pooled),
        .valid_mac    (valid_mac),
        .busy         (busy),
        .done         (done),
        .wc_conf      (wc_conf),
        .wc_st_addr   (wc_st_addr),
        .wc_linelen   (wc_linelen),
        .wc_pooled    (wc_pooled),
        .wc_valid_mac (wc_valid_mac),
        .wc_idle      (wc_idle)
`ifdef STAT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepted descriptor; returns positioned in cycle 1.
    task automatic drive_start(input logic [W-1:0] b, input logic [AL-1:0] s,
                               input logic [9:0] n, input logic [9:0] l,
                               input logic p, input logic [1:0] vm);
        base_addr   = b;
        addr_stride = s;
        num_lines   = n;
        linelen     = l;
        pooled      = p;
        valid_mac   = vm;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        base_addr   = '0;
        addr_stride = '0;
        num_lines   = '0;
        linelen     = '0;
        pooled      = 1'b0;
        valid_mac   = 2'b00;
    endtask

    function automatic logic [W-1:0] line_addr(input logic [W-1:0] b, input logic [AL-1:0] s,
                                               input int k);
        logic [W-1:0]  r;
        logic [AL-1:0] a;
        r = '0;
        for (int j = 0; j < XM; j++) begin
            a = b[j*AL +: AL];
            r[j*AL +: AL] = a + AL'(k * int'(s));
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wc_conf !== 1'b0 || wc_st_addr !== '0 ||
            wc_linelen !== '0 || wc_pooled !== 1'b0 || wc_valid_mac !== 2'b00) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b conf=%b addr=%h len=%0d pool=%b vm=%0d required all zero",
                     busy, done, wc_conf, wc_st_addr, wc_linelen, wc_pooled, wc_valid_mac);
        end
`ifdef STAT_EN
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL reset_stall: got %0d required 0", stall_cycles);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [W-1:0] b;
        exp_t         e;
        b = {13'd300, 13'd200, 13'd100, 13'd0};
        exp_q.delete();
        for (int k = 0; k < 3; k++) exp_q.push_back('{cyc: 2 + 3 * k, addr: line_addr(b, 13'd16, k)});
        wc_idle = 1'b1;
        drive_start(b, 13'd16, 10'd3, 10'd8, 1'b1, 2'd1);
        for (int c = 1; c <= 14; c++) begin
            if (wc_conf) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL basic_conf: unexpected conf at cycle %0d", c);
                end else begin
                    e = exp_q.pop_front();
                    if (c != e.cyc || wc_st_addr !== e.addr || wc_linelen !== 10'd8 ||
                        wc_pooled !== 1'b1 || wc_valid_mac !== 2'd1) begin
                        failures++;
                        $display("FAIL basic_conf: cycle %0d addr %h len %0d pool %b vm %0d required cycle %0d addr %h len 8 pool 1 vm 1",
                                 c, wc_st_addr, wc_linelen, wc_pooled, wc_valid_mac, e.cyc, e.addr);
                    end
                end
            end
            if (c <= 10) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_busy: cycle %0d got %b required 1", c, busy);
                end
            end
            checks++;
            if (done !== (c == 11)) begin
                failures++;
                $display("FAIL basic_done: cycle %0d got %b required %b", c, done, c == 11);
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_end: %0d confs missing, busy %b required 0 missing busy 0", exp_q.size(), busy);
        end
`ifdef STAT_EN
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL basic_stall: got %0d required 0", stall_cycles);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [W-1:0] b;
        exp_t         e;
        int           last;
        logic         prev_idle;
        b = {13'd7, 13'd5, 13'd3, 13'd1};
        exp_q.delete();
        for (int k = 0; k < 3; k++) exp_q.push_back('{cyc: 2 + 7 * k, addr: line_addr(b, 13'd100, k)});
        last      = -100;
        prev_idle = 1'b1;
        wc_idle   = 1'b1;
        drive_start(b, 13'd100, 10'd3, 10'd4, 1'b0, 2'd2);
        for (int c = 1; c <= 22; c++) begin
            wc_idle = !(c > last && c <= last + 5);
            if (wc_conf) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_conf: unexpected conf at cycle %0d", c);
                end else begin
                    e = exp_q.pop_front();
                    if (c != e.cyc || wc_st_addr !== e.addr || prev_idle !== 1'b1) begin
                        failures++;
                        $display("FAIL bp_conf: cycle %0d addr %h prev_idle %b required cycle %0d addr %h prev_idle 1",
                                 c, wc_st_addr, prev_idle, e.cyc, e.addr);
                    end
                end
                last = c;
            end
            checks++;
            if (done !== (c == 19)) begin
                failures++;
                $display("FAIL bp_done: cycle %0d got %b required %b", c, done, c == 19);
            end
            prev_idle = wc_idle;
            tick();
        end
        wc_idle = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_count: %0d confs missing required 0", exp_q.size());
        end
`ifdef STAT_EN
        checks++;
        if (stall_cycles !== 32'd8) begin
            failures++;
            $display("FAIL bp_stall: got %0d required 8", stall_cycles);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [W-1:0] b;
        exp_t         e;
        int           n;
        b = {13'd30, 13'd8190, 13'd20, 13'd10};
        exp_q.delete();
        for (int k = 0; k < 2; k++) exp_q.push_back('{cyc: 2 + 3 * k, addr: line_addr(b, 13'd4, k)});
        n = 0;
        wc_idle = 1'b1;
        drive_start(b, 13'd4, 10'd2, 10'd1, 1'b0, 2'd0);
        for (int c = 1; c <= 10; c++) begin
            if (wc_conf) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wrap_conf: unexpected conf at cycle %0d", c);
                end else begin
                    e = exp_q.pop_front();
                    if (c != e.cyc || wc_st_addr !== e.addr) begin
                        failures++;
                        $display("FAIL wrap_conf: cycle %0d addr %h required cycle %0d addr %h",
                                 c, wc_st_addr, e.cyc, e.addr);
                    end
                end
                if (n == 2) begin
                    checks++;
                    if (wc_st_addr[2*AL +: AL] !== 13'd2 || wc_st_addr[0 +: AL] !== 13'd14 ||
                        wc_st_addr[AL +: AL] !== 13'd24 || wc_st_addr[3*AL +: AL] !== 13'd34) begin
                        failures++;
                        $display("FAIL wrap_lanes: got %0d %0d %0d %0d required 14 24 2 34",
                                 wc_st_addr[0 +: AL], wc_st_addr[AL +: AL],
                                 wc_st_addr[2*AL +: AL], wc_st_addr[3*AL +: AL]);
                    end
                end
            end
            checks++;
            if (done !== (c == 8)) begin
                failures++;
                $display("FAIL wrap_done: cycle %0d got %b required %b", c, done, c == 8);
            end
            tick();
        end
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL wrap_count: got %0d confs required 2", n);
        end
    endtask

    task automatic test_zero_length();
        logic [9:0] nl;
        logic [9:0] ll;
        wc_idle = 1'b1;
        for (int t = 0; t < 2; t++) begin
            nl = (t == 0) ? 10'd0 : 10'd5;
            ll = (t == 0) ? 10'd6 : 10'd0;
            drive_start({13'd4, 13'd3, 13'd2, 13'd1}, 13'd8, nl, ll, 1'b1, 2'd3);
            for (int c = 1; c <= 5; c++) begin
                checks++;
                if (wc_conf !== 1'b0 || done !== (c == 2)) begin
                    failures++;
                    $display("FAIL zero_len%0d: cycle %0d conf %b done %b required conf 0 done %b",
                             t, c, wc_conf, done, c == 2);
                end
                tick();
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] b;
        exp_t         e;
        b = {13'd44, 13'd33, 13'd22, 13'd11};
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back('{cyc: 2 + 3 * k, addr: line_addr(b, 13'd50, k)});
        wc_idle = 1'b1;
        drive_start(b, 13'd50, 10'd4, 10'd8, 1'b1, 2'd2);
        for (int c = 1; c <= 16; c++) begin
            if (wc_conf) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ign_conf: unexpected conf at cycle %0d", c);
                end else begin
                    e = exp_q.pop_front();
                    if (c != e.cyc || wc_st_addr !== e.addr) begin
                        failures++;
                        $display("FAIL ign_conf: cycle %0d addr %h required cycle %0d addr %h",
                                 c, wc_st_addr, e.cyc, e.addr);
                    end
                end
            end
            if (c <= 14) begin
                checks++;
                if (wc_linelen !== 10'd8 || wc_pooled !== 1'b1 || wc_valid_mac !== 2'd2) begin
                    failures++;
                    $display("FAIL ign_latched: cycle %0d len %0d pool %b vm %0d required 8 1 2",
                             c, wc_linelen, wc_pooled, wc_valid_mac);
                end
            end
            checks++;
            if (done !== (c == 14)) begin
                failures++;
                $display("FAIL ign_done: cycle %0d got %b required %b", c, done, c == 14);
            end
            if (c == 3) begin
                base_addr   = {13'd999, 13'd888, 13'd777, 13'd666};
                addr_stride = 13'd3;
                num_lines   = 10'd9;
                linelen     = 10'd33;
                pooled      = 1'b0;
                valid_mac   = 2'd1;
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL ign_count: %0d confs missing required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_tile();
        logic [W-1:0] b;
        exp_t         e;
        wc_idle = 1'b1;
        drive_start({13'd4, 13'd3, 13'd2, 13'd1}, 13'd10, 10'd4, 10'd7, 1'b1, 2'd3);
        tick();
        checks++;
        if (wc_conf !== 1'b1) begin
            failures++;
            $display("FAIL rst_first_conf: got %b required 1", wc_conf);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || wc_conf !== 1'b0 || done !== 1'b0 || wc_st_addr !== '0 ||
            wc_linelen !== '0 || wc_pooled !== 1'b0 || wc_valid_mac !== 2'b00) begin
            failures++;
            $display("FAIL rst_mid: busy %b conf %b done %b addr %h len %0d pool %b vm %0d required all zero",
                     busy, wc_conf, done, wc_st_addr, wc_linelen, wc_pooled, wc_valid_mac);
        end
        rst_n = 1'b1;
        tick();
        b = {13'd80, 13'd60, 13'd40, 13'd20};
        exp_q.delete();
        for (int k = 0; k < 2; k++) exp_q.push_back('{cyc: 2 + 3 * k, addr: line_addr(b, 13'd5, k)});
        drive_start(b, 13'd5, 10'd2, 10'd3, 1'b0, 2'd1);
        for (int c = 1; c <= 10; c++) begin
            if (wc_conf) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rst_clean_conf: unexpected conf at cycle %0d", c);
                end else begin
                    e = exp_q.pop_front();
                    if (c != e.cyc || wc_st_addr !== e.addr || wc_linelen !== 10'd3) begin
                        failures++;
                        $display("FAIL rst_clean_conf: cycle %0d addr %h len %0d required cycle %0d addr %h len 3",
                                 c, wc_st_addr, wc_linelen, e.cyc, e.addr);
                    end
                end
            end
            checks++;
            if (done !== (c == 8)) begin
                failures++;
                $display("FAIL rst_clean_done: cycle %0d got %b required %b", c, done, c == 8);
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rst_clean_count: %0d confs missing required 0", exp_q.size());
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        addr_stride = '0;
        num_lines   = '0;
        linelen     = '0;
        pooled      = 1'b0;
        valid_mac   = 2'b00;
        wc_idle     = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_ignored_start();
        test_reset_mid_tile();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
